// File: rtl/decode_align_queue_pkg.sv
// decode_align_queue_pkg: shared entry/output types for the decode align queue
package decode_align_queue_pkg;
  localparam int ECAUSE_MAX_W = 16;
  typedef struct packed {
    logic [15:0]             half;
    logic [31:0]             pc;
    logic                    exc;
    logic [ECAUSE_MAX_W-1:0] ecause;
  } align_entry_type;
  typedef struct packed {
    logic                    valid;
    logic [31:0]             pc;
    logic [31:0]             npc;
    logic [31:0]             instr;
    logic                    exception;
    logic [ECAUSE_MAX_W-1:0] ecause;
    logic [31:0]             etval;
  } align_out_type;
  localparam align_entry_type init_align_entry = '0;
  localparam align_out_type init_align_out = '0;
endpackage

// File: rtl/align_head_decode.sv
// align_head_decode: combinational inspection of the queue head into a decode slot
module align_head_decode
  import decode_align_queue_pkg::*;
#(
  parameter int CW = 4
) (
  input  align_entry_type h0,
  input  align_entry_type h1,
  input  logic [CW-1:0]   count,
  output align_out_type   out,
  output logic            two
);
  logic need2, has2, ok, exc;
  always_comb begin
    need2 = h0.half[1:0] == 2'b11;
    has2 = count >= CW'(2);
    two = need2 && has2;
    ok = (count != '0) && (!need2 || has2 || h0.exc);
    exc = ok && (h0.exc || (two && h1.exc));
    out = init_align_out;
    out.valid = ok;
    out.pc = ok ? h0.pc : '0;
    out.npc = ok ? h0.pc + (need2 ? 32'd4 : 32'd2) : '0;
    out.instr = ok ? {two ? h1.half : 16'h0, h0.half} : '0;
    out.exception = exc;
    out.ecause = exc ? (h0.exc ? h0.ecause : h1.ecause) : '0;
    out.etval = exc ? (h0.exc ? h0.pc : h1.pc) : '0;
  end
endmodule

// File: rtl/decode_align_queue.sv
// decode_align_queue: halfword queue realigning fetch words into RV32C/RV32 instructions for decode
module decode_align_queue
  import decode_align_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ECAUSE_W = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [31:0]                fetch_pc,
  input  logic [31:0]                fetch_rdata,
  input  logic                       fetch_exception,
  input  logic [ECAUSE_W-1:0]        fetch_ecause,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_pc,
  output logic [31:0]                dec_npc,
  output logic [31:0]                dec_instr,
  output logic                       dec_exception,
  output logic [ECAUSE_W-1:0]        dec_ecause,
  output logic [31:0]                dec_etval,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  align_entry_type mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  align_out_type head;
  logic two, push, pop, unused_ecause;
  logic [CW-1:0] pushed, popped;
  assign fetch_ready = count <= CW'(DEPTH - 2);
  assign push = fetch_valid && fetch_ready && !flush;
  assign pop = head.valid && dec_ready && !flush;
  assign pushed = push ? (fetch_pc[1] ? CW'(1) : CW'(2)) : '0;
  assign popped = pop ? (two ? CW'(2) : CW'(1)) : '0;
  align_head_decode #(.CW(CW)) u_head (
    .h0(mem[rptr]),
    .h1(mem[rptr + AW'(1)]),
    .count(count),
    .out(head),
    .two(two)
  );
  assign dec_valid = head.valid;
  assign dec_pc = head.pc;
  assign dec_npc = head.npc;
  assign dec_instr = head.instr;
  assign dec_exception = head.exception;
  assign dec_ecause = head.ecause[ECAUSE_W-1:0];
  assign dec_etval = head.etval;
  assign unused_ecause = ^head.ecause;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_align_entry;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{half: fetch_pc[1] ? fetch_rdata[31:16] : fetch_rdata[15:0], pc: fetch_pc,
                       exc: fetch_exception, ecause: ECAUSE_MAX_W'(fetch_ecause)};
        if (!fetch_pc[1])
          mem[wptr + AW'(1)] <= '{half: fetch_rdata[31:16], pc: fetch_pc + 32'd2,
                                  exc: fetch_exception, ecause: ECAUSE_MAX_W'(fetch_ecause)};
      end
      wptr <= wptr + AW'(pushed);
      rptr <= rptr + AW'(popped);
      count <= count + pushed - popped;
    end
  end
  assert property (@(posedge clock) disable iff (reset) !(fetch_valid && !fetch_ready && !flush));
endmodule

// File: tb/tb_decode_align_queue.sv
// tb_decode_align_queue: scoreboard bench for the decode align queue
module tb_decode_align_queue;
  logic clock = 0, reset, flush, fetch_valid, fetch_ready, fetch_exception;
  logic [31:0] fetch_pc, fetch_rdata;
  logic [3:0] fetch_ecause, dec_ecause, count;
  logic dec_valid, dec_ready, dec_exception;
  logic [31:0] dec_pc, dec_npc, dec_instr, dec_etval;
  typedef struct {
    logic [31:0] instr, pc, npc, etval;
    logic        exc;
    logic [3:0]  ec;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  decode_align_queue #(.DEPTH(8), .ECAUSE_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_rdata(fetch_rdata), .fetch_exception(fetch_exception), .fetch_ecause(fetch_ecause),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_npc(dec_npc),
    .dec_instr(dec_instr), .dec_exception(dec_exception), .dec_ecause(dec_ecause),
    .dec_etval(dec_etval), .count(count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic expect_i(input logic [31:0] instr, pc, npc, input logic exc = 0,
                          input logic [3:0] ec = 0, input logic [31:0] etval = 0);
    exp_t e;
    e.instr = instr; e.pc = pc; e.npc = npc; e.exc = exc; e.ec = ec; e.etval = etval;
    q.push_back(e);
  endtask
  task automatic push(input logic [31:0] pc, data, input logic exc = 0, input logic [3:0] ec = 0);
    int n = 0;
    while (!fetch_ready && n < 50) begin
      step();
      n++;
    end
    if (!fetch_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout pc=%h actual fetch_ready=0 required=1", pc);
    end else begin
      fetch_valid = 1; fetch_pc = pc; fetch_rdata = data; fetch_exception = exc; fetch_ecause = ec;
      step();
      fetch_valid = 0; fetch_exception = 0; fetch_ecause = 0;
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (dec_valid && dec_ready && !flush) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected actual instr=%h pc=%h required=no issue", dec_instr, dec_pc);
        end else begin
          e = q.pop_front();
          if (dec_instr !== e.instr || dec_pc !== e.pc || dec_npc !== e.npc ||
              dec_exception !== e.exc || dec_ecause !== e.ec || dec_etval !== e.etval) begin
            failures++;
            $display("FAIL sb_issue actual instr=%h pc=%h npc=%h exc=%b ec=%h etval=%h required instr=%h pc=%h npc=%h exc=%b ec=%h etval=%h",
                     dec_instr, dec_pc, dec_npc, dec_exception, dec_ecause, dec_etval,
                     e.instr, e.pc, e.npc, e.exc, e.ec, e.etval);
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    int n;
    reset = 1; flush = 0; fetch_valid = 0; fetch_pc = 0; fetch_rdata = 0;
    fetch_exception = 0; fetch_ecause = 0; dec_ready = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(dec_valid), 0);
    chk("rst_fetch_ready", 32'(fetch_ready), 1);
    chk("rst_instr", dec_instr, 0);
    chk("rst_exception", 32'(dec_exception), 0);
    step();
    expect_i(32'h00A00093, 32'h0, 32'h4);
    push(32'h0, 32'h00A00093);
    @(negedge clock);
    chk("t1_count", 32'(count), 2);
    chk("t1_valid", 32'(dec_valid), 1);
    chk("t1_npc", dec_npc, 32'h4);
    step();
    @(negedge clock);
    chk("t1_count_pop", 32'(count), 0);
    step();
    expect_i(32'h4485, 32'h100, 32'h102);
    expect_i(32'h4501, 32'h102, 32'h104);
    push(32'h100, 32'h45014485);
    idle(3);
    expect_i(32'h4501, 32'h200, 32'h202);
    expect_i(32'h00130093, 32'h202, 32'h206);
    expect_i(32'h0, 32'h206, 32'h208);
    push(32'h200, 32'h00934501);
    @(negedge clock);
    step();
    @(negedge clock);
    chk("straddle_count", 32'(count), 1);
    chk("straddle_valid", 32'(dec_valid), 0);
    chk("straddle_instr_zero", dec_instr, 0);
    chk("straddle_pc_zero", dec_pc, 0);
    step();
    push(32'h204, 32'h00000013);
    idle(3);
    expect_i(32'h01130093, 32'h302, 32'h306);
    expect_i(32'h4501, 32'h306, 32'h308);
    push(32'h302, 32'h00930001);
    @(negedge clock);
    chk("misalign_count", 32'(count), 1);
    chk("misalign_valid", 32'(dec_valid), 0);
    step();
    push(32'h304, 32'h45010113);
    idle(3);
    dec_ready = 0;
    expect_i(32'h00000013, 32'h400, 32'h404, 1, 4'h1, 32'h400);
    push(32'h400, 32'h00000013, 1, 4'h1);
    @(negedge clock);
    chk("fault_count", 32'(count), 2);
    chk("fault_valid", 32'(dec_valid), 1);
    chk("fault_exception", 32'(dec_exception), 1);
    chk("fault_etval", dec_etval, 32'h400);
    step();
    dec_ready = 1;
    idle(2);
    expect_i(32'h00000093, 32'h502, 32'h506, 1, 4'h5, 32'h502);
    push(32'h502, 32'h00930000, 1, 4'h5);
    @(negedge clock);
    chk("fault_short_count", 32'(count), 1);
    chk("fault_short_valid", 32'(dec_valid), 1);
    step();
    idle(2);
    expect_i(32'h00130093, 32'h602, 32'h606, 1, 4'h7, 32'h604);
    expect_i(32'h0, 32'h606, 32'h608, 1, 4'h7, 32'h606);
    push(32'h602, 32'h00930000);
    push(32'h604, 32'h00000013, 1, 4'h7);
    idle(4);
    expect_i(32'h4485, 32'h900, 32'h902);
    expect_i(32'h4501, 32'h902, 32'h904);
    expect_i(32'h00A00093, 32'h904, 32'h908);
    push(32'h900, 32'h45014485);
    push(32'h904, 32'h00A00093);
    idle(5);
    @(negedge clock);
    chk("b2b_drained", 32'(count), 0);
    step();
    dec_ready = 0;
    push(32'h702, 32'h44850000);
    push(32'h704, 32'h45014485);
    push(32'h708, 32'h45014485);
    @(negedge clock);
    chk("fill_count5", 32'(count), 5);
    chk("fill_ready5", 32'(fetch_ready), 1);
    chk("fill_pc5", dec_pc, 32'h702);
    step();
    push(32'h70C, 32'h45014485);
    @(negedge clock);
    chk("fill_count7", 32'(count), 7);
    chk("fill_ready7", 32'(fetch_ready), 0);
    chk("stall_pc", dec_pc, 32'h702);
    chk("stall_instr", dec_instr, 32'h4485);
    step();
    fetch_valid = 1; fetch_pc = 32'h710; fetch_rdata = 32'h00A00093; flush = 1;
    step();
    fetch_valid = 0; flush = 0;
    @(negedge clock);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(dec_valid), 0);
    chk("flush_ready", 32'(fetch_ready), 1);
    step();
    dec_ready = 1;
    idle(3);
    @(negedge clock);
    chk("flush_dropped_valid", 32'(dec_valid), 0);
    chk("flush_dropped_count", 32'(count), 0);
    step();
    expect_i(32'h00A00093, 32'h800, 32'h804);
    push(32'h800, 32'h00A00093);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("sb_drain", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
